// File: rtl/sram_bist_seq.sv
// Self-test sequencer: writes a pattern byte to each address of a window through the
// SRAM controller register interface, reads it back, and tallies mismatches.
// Optional macro SEQ_STOP_ON_ERR_EN: finish the test at the first mismatch.
module sram_bist_seq #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              pat_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       enable,
  output logic [31:0]       send,
  output logic [31:0]       sta_addr,
  output logic [31:0]       area_cfg,
  output logic [31:0]       op_cfg,
  input  logic [31:0]       status,
  input  logic [31:0]       outp_data,
  input  logic [31:0]       outp_addr
);
  localparam int TOUT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CFG_WAIT, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT, S_CHK, S_NEXT, S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q, cur_addr_q, first_err_q;
  logic [ADDR_W:0]     len_q, idx_q;
  logic                pat_q, seen_q, done_q, pass_q, timeout_q;
  logic [15:0]         err_cnt_q;
  logic [TOUT_W-1:0]   tmo_q;
  logic [31:0]         enable_q, send_q, sta_addr_q;

  logic [ADDR_W-1:0]        win_addr_d;
  logic [ADDR_W:0]          idx_d;
  logic [ADDR_W+DATA_W-1:0] addr_ext;
  logic [DATA_W-1:0]        exp_data;
  logic                     mismatch, tmo_hit;
  logic                     unused_ok;

  assign win_addr_d = base_q + idx_q[ADDR_W-1:0];
  assign idx_d      = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign addr_ext   = {{DATA_W{1'b0}}, cur_addr_q};
  // Pattern is derived from the wrapped address, so it stays consistent across the wrap.
  assign exp_data   = pat_q ? ~addr_ext[DATA_W-1:0] : addr_ext[DATA_W-1:0];
  assign mismatch   = (outp_data[DATA_W-1:0] != exp_data) || (outp_addr[ADDR_W-1:0] != cur_addr_q);
  assign tmo_hit    = (tmo_q == TOUT_W'(TIMEOUT - 1));
  assign unused_ok  = ^{status[31:8], outp_data[31:DATA_W], outp_addr[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cur_addr_q  <= '0;
      first_err_q <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      pat_q       <= 1'b0;
      seen_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      tmo_q       <= '0;
      enable_q    <= '0;
      send_q      <= '0;
      sta_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            idx_q       <= '0;
            base_q      <= base_addr;
            len_q       <= length;
            pat_q       <= pat_sel;
            if (length == '0) begin
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CFG;
            end
          end
        end
        S_CFG: begin
          enable_q   <= '0;
          sta_addr_q <= {{(32-ADDR_W){1'b0}}, win_addr_d};
          cur_addr_q <= win_addr_d;
          tmo_q      <= '0;
          state_q    <= S_CFG_WAIT;
        end
        S_CFG_WAIT: begin
          if (status[7:0] == 8'h01) begin
            state_q <= S_WR;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            enable_q  <= '0;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TOUT_W'(1);
          end
        end
        S_WR: begin
          // Toggling bit 31 makes every command a fresh send value for the controller.
          enable_q <= 32'h1;
          send_q   <= {~send_q[31], {(31-DATA_W){1'b0}}, exp_data};
          tmo_q    <= '0;
          seen_q   <= 1'b0;
          state_q  <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (seen_q && status[7:0] == 8'h02) begin
            state_q <= S_RD;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            enable_q  <= '0;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TOUT_W'(1);
            if (status[7:0] == 8'h08) seen_q <= 1'b1;
          end
        end
        S_RD: begin
          enable_q <= 32'h3;
          send_q   <= {~send_q[31], {(31-ADDR_W){1'b0}}, cur_addr_q};
          tmo_q    <= '0;
          seen_q   <= 1'b0;
          state_q  <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (seen_q && status[7:0] == 8'h02) begin
            state_q <= S_CHK;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            enable_q  <= '0;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TOUT_W'(1);
            if (status[7:0] == 8'h04) seen_q <= 1'b1;
          end
        end
        S_CHK: begin
          state_q <= S_NEXT;
          if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (err_cnt_q == '0) first_err_q <= cur_addr_q;
`ifdef SEQ_STOP_ON_ERR_EN
            done_q   <= 1'b1;
            enable_q <= '0;
            state_q  <= S_DONE;
`endif
          end
        end
        S_NEXT: begin
          idx_q <= idx_d;
          if (idx_d == len_q) begin
            done_q   <= 1'b1;
            pass_q   <= (err_cnt_q == '0) && !timeout_q;
            enable_q <= '0;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_CFG;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign enable         = enable_q;
  assign send           = send_q;
  assign sta_addr       = sta_addr_q;
  assign area_cfg       = 32'h0;
  assign op_cfg         = 32'h0000_0004;
endmodule

// File: tb/tb_sram_bist_seq.sv
// Directed bench for sram_bist_seq with a behavioural SRAM controller model
// (CONFIG/IDLE/READ/WRITE status, stuck-at fault and hang injection).
module tb_sram_bist_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        pat_sel = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [9:0]  first_err_addr;
  logic [31:0] enable, send, sta_addr, area_cfg, op_cfg;
  logic [31:0] status = 32'h1;
  logic [31:0] outp_data = '0;
  logic [31:0] outp_addr = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_bist_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .pat_sel(pat_sel), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .enable(enable), .send(send), .sta_addr(sta_addr), .area_cfg(area_cfg),
    .op_cfg(op_cfg), .status(status), .outp_data(outp_data), .outp_addr(outp_addr)
  );

  // Controller model: a changed send value while enabled launches one command.
  logic [7:0]  mem [0:1023];
  logic [31:0] prev_send = '0;
  logic        hang_en = 1'b0, fault_en = 1'b0, prefill_req = 1'b0;
  logic [9:0]  fault_addr = 10'h005;

  always @(posedge clk) begin
    prev_send <= send;
    if (prefill_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'hAA;
    end
    if (!reset_n)                status <= 32'h01;
    else if (!enable[0])         status <= 32'h01;
    else if (hang_en)            status <= 32'h08;
    else if (send != prev_send) begin
      if (enable[2:1] == 2'b00) begin
        mem[sta_addr[9:0]] <= (fault_en && sta_addr[9:0] == fault_addr) ? (send[7:0] & 8'hFE) : send[7:0];
        status <= 32'h08;
      end else begin
        outp_data <= {24'h0, mem[send[9:0]]};
        outp_addr <= {22'h0, send[9:0]};
        status    <= 32'h04;
      end
    end else begin
      status <= 32'h02;
    end
  end

  task automatic prefill();
    @(negedge clk); prefill_req = 1'b1;
    @(negedge clk); prefill_req = 1'b0;
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [10:0] l, input logic p);
    @(negedge clk);
    base_addr = b; length = l; pat_sel = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b want 0", done); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL rst_pass: got %0b want 0", pass); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
    tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL rst_err_cnt: got %h want 0", err_cnt); end
    tests++; if (enable !== 32'h0) begin fails++; $display("FAIL rst_enable: got %h want 0", enable); end
    tests++; if (send !== 32'h0) begin fails++; $display("FAIL rst_send: got %h want 0", send); end
    tests++; if (sta_addr !== 32'h0) begin fails++; $display("FAIL rst_sta_addr: got %h want 0", sta_addr); end
    tests++; if (area_cfg !== 32'h0) begin fails++; $display("FAIL rst_area_cfg: got %h want 0", area_cfg); end
    tests++; if (op_cfg !== 32'h4) begin fails++; $display("FAIL rst_op_cfg: got %h want 4", op_cfg); end
    reset_n = 1'b1;
    $display("[TB] test_reset checked");
  endtask

  task automatic test_good();
    bit ok;
    prefill();
    pulse_start(10'h000, 11'd16, 1'b0);
    wait_done(2000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL good_done: got no done want done"); end
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL good_pass: got %0b want 1", pass); end
    tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL good_err_cnt: got %h want 0", err_cnt); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL good_timeout: got %0b want 0", timeout); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL good_busy_after: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL good_done_pulse: got %0b want 0", done); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e = 8'(i);
      tests++; if (mem[i] !== e) begin fails++; $display("FAIL good_mem[%0d]: got %h want %h", i, mem[i], e); end
    end
    $display("[TB] test_good base=000 len=16 pass=%0b err=%0d", pass, err_cnt);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [9:0] a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [7:0] d [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    prefill();
    pulse_start(10'h3FE, 11'd4, 1'b1);
    wait_done(1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_done: got no done want done"); end
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL wrap_pass: got %0b want 1", pass); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[a[i]] !== d[i]) begin fails++; $display("FAIL wrap_mem[%h]: got %h want %h", a[i], mem[a[i]], d[i]); end
    end
    tests++; if (mem[2] !== 8'hAA) begin fails++; $display("FAIL wrap_overrun: got %h want aa", mem[2]); end
    $display("[TB] test_wrap base=3fe len=4 pass=%0b", pass);
  endtask

  task automatic test_fault();
    bit ok;
    prefill();
    fault_en = 1'b1; fault_addr = 10'h005;
    pulse_start(10'h000, 11'd8, 1'b0);
    wait_done(1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL fault_done: got no done want done"); end
    tests++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL fault_err_cnt: got %0d want 1", err_cnt); end
    tests++; if (first_err_addr !== 10'h005) begin fails++; $display("FAIL fault_first_addr: got %h want 005", first_err_addr); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL fault_pass: got %0b want 0", pass); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL fault_timeout: got %0b want 0", timeout); end
`ifdef SEQ_STOP_ON_ERR_EN
    tests++; if (mem[6] !== 8'hAA) begin fails++; $display("FAIL fault_stop_skip: got %h want aa", mem[6]); end
`else
    tests++; if (mem[7] !== 8'h07) begin fails++; $display("FAIL fault_continue: got %h want 07", mem[7]); end
`endif
    fault_en = 1'b0;
    $display("[TB] test_fault stuck bit0 @005 err=%0d first=%h", err_cnt, first_err_addr);
  endtask

  task automatic test_hang();
    int cnt = 0;
    bit seen = 1'b0;
    hang_en = 1'b1;
    pulse_start(10'h000, 11'd4, 1'b0);
    for (int c = 0; c < 50; c++) begin
      if (enable === 32'h1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL hang_wr_issue: got enable %h want 1", enable); end
    while (cnt < 200 && done !== 1'b1) begin @(negedge clk); cnt++; end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL hang_done: got %0b want 1", done); end
    tests++; if (cnt != 64) begin fails++; $display("FAIL hang_cycles: got %0d want 64", cnt); end
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL hang_timeout: got %0b want 1", timeout); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL hang_pass: got %0b want 0", pass); end
    tests++; if (enable !== 32'h0) begin fails++; $display("FAIL hang_enable: got %h want 0", enable); end
    hang_en = 1'b0;
    @(negedge clk);
    $display("[TB] test_hang cycles_in_wait=%0d timeout=%0b", cnt, timeout);
  endtask

  task automatic test_zero_len();
    pulse_start(10'h123, 11'd0, 1'b0);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %0b want 1", done); end
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL zero_pass: got %0b want 1", pass); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL zero_timeout_clr: got %0b want 0", timeout); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse: got %0b want 0", done); end
    $display("[TB] test_zero_len pass=%0b", pass);
  endtask

  task automatic test_back_to_back();
    bit ok;
    prefill();
    pulse_start(10'h000, 11'd16, 1'b0);
    repeat (30) @(negedge clk);
    base_addr = 10'h200; length = 11'd0; pat_sel = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL ign_start_done: got %0b want 0", done); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_start_busy: got %0b want 1", busy); end
    wait_done(2000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ign_done: got no done want done"); end
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL ign_pass: got %0b want 1", pass); end
    tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL ign_err_cnt: got %0d want 0", err_cnt); end
    tests++; if (mem[15] !== 8'h0F) begin fails++; $display("FAIL ign_mem15: got %h want 0f", mem[15]); end
    $display("[TB] test_back_to_back ignored start, pass=%0b", pass);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    prefill();
`ifndef SEQ_STOP_ON_ERR_EN
    fault_en = 1'b1; fault_addr = 10'h005;
`endif
    pulse_start(10'h005, 11'd4, 1'b0);
`ifndef SEQ_STOP_ON_ERR_EN
    for (int c = 0; c < 200; c++) begin
      if (err_cnt !== 16'h0) break;
      @(negedge clk);
    end
    tests++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL mid_err_seen: got %0d want 1", err_cnt); end
`endif
    for (int c = 0; c < 100; c++) begin
      if (enable === 32'h3) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL mid_rd_issue: got enable %h want 3", enable); end
    reset_n = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %0b want 0", busy); end
    tests++; if (enable !== 32'h0) begin fails++; $display("FAIL mid_enable: got %h want 0", enable); end
    tests++; if (err_cnt !== 16'h0) begin fails++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
    reset_n = 1'b1;
    fault_en = 1'b0;
    pulse_start(10'h010, 11'd4, 1'b1);
    wait_done(1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_rerun_done: got no done want done"); end
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL mid_rerun_pass: got %0b want 1", pass); end
    tests++; if (mem[10'h013] !== 8'hEC) begin fails++; $display("FAIL mid_rerun_mem: got %h want ec", mem[10'h013]); end
    $display("[TB] test_reset_mid rerun pass=%0b", pass);
  endtask

  initial begin
    test_reset();
    test_good();
    test_wrap();
    test_fault();
    test_hang();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
